// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline run-control block:
// FSM state encodings and the debug UART command bytes.
package pipeline_ctrl_pkg;

  localparam int unsigned STATE_BITS = 3;
  localparam int unsigned CMD_BITS   = 8;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DUMP   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [CMD_BITS-1:0] CMD_RUN   = 8'h43;
  localparam logic [CMD_BITS-1:0] CMD_STEP  = 8'h53;
  localparam logic [CMD_BITS-1:0] CMD_BREAK = 8'h42;
  localparam logic [CMD_BITS-1:0] CMD_CLEAR = 8'h58;

  // True when a valid strobe carries the given command byte.
  function automatic logic is_cmd(input logic                valid,
                                  input logic [CMD_BITS-1:0] cmd,
                                  input logic [CMD_BITS-1:0] code);
    return valid && (cmd == code);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                inc,
  input  logic                clr,
  output logic [CNT_BITS-1:0] count
);

  always_ff @(posedge i_clk) begin
    if (i_reset || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_BITS{1'b1}})) begin
      count <= count + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run-control FSM: gates the pipeline enable for continuous run / single step and
// hands off to the register dump engine. Optional watchdog: define PIPE_RUN_WDOG_EN.
module pipeline_run_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned          CNT_BITS   = 32,
  parameter logic [CNT_BITS-1:0]  WDOG_LIMIT = CNT_BITS'(100000)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [7:0]            i_cmd,
  input  logic                  i_halt,
  input  logic                  i_dump_ack,
  output logic                  o_enable,
  output logic                  o_pipe_reset,
  output logic                  o_dump_req,
  output logic                  o_halted,
  output logic                  o_timeout,
  output logic [CNT_BITS-1:0]   o_cycle_count,
  output logic [2:0]            o_state
);

  state_e state;
  state_e state_next;
  logic   halted_q;
  logic   timeout_q;
  logic   pipe_reset_q;
  logic   halt_set;
  logic   timeout_set;
  logic   clear_hit;
  logic   wdog_hit;
  logic   cmd_run;
  logic   cmd_step;
  logic   cmd_break;
  logic   cmd_clear;

  assign cmd_run   = is_cmd(i_cmd_valid, i_cmd, CMD_RUN);
  assign cmd_step  = is_cmd(i_cmd_valid, i_cmd, CMD_STEP);
  assign cmd_break = is_cmd(i_cmd_valid, i_cmd, CMD_BREAK);
  assign cmd_clear = is_cmd(i_cmd_valid, i_cmd, CMD_CLEAR);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; priority in RUN is halt, then watchdog, then break
  always_comb begin
    state_next  = state;
    halt_set    = 1'b0;
    timeout_set = 1'b0;
    clear_hit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_run) begin
          state_next = ST_RUN;
        end else if (cmd_step) begin
          state_next = ST_STEP;
        end else if (cmd_clear) begin
          clear_hit = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_next = ST_DUMP;
          halt_set   = 1'b1;
        end else if (wdog_hit) begin
          state_next  = ST_DUMP;
          timeout_set = 1'b1;
        end else if (cmd_break) begin
          state_next = ST_DUMP;
        end
      end
      ST_STEP: begin
        state_next = ST_DUMP;
        halt_set   = i_halt;
      end
      ST_DUMP: begin
        if (i_dump_ack) begin
          state_next = (halted_q || timeout_q) ? ST_HALTED : ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (cmd_clear) begin
          state_next = ST_IDLE;
          clear_hit  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    o_enable   = 1'b0;
    o_dump_req = 1'b0;
    unique case (state)
      ST_RUN, ST_STEP: o_enable   = 1'b1;
      ST_DUMP:         o_dump_req = 1'b1;
      default: ;
    endcase
  end

  // Sticky halt flag and the one-cycle pipeline reset pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      halted_q     <= 1'b0;
      pipe_reset_q <= 1'b0;
    end else begin
      halted_q     <= clear_hit ? 1'b0 : (halted_q || halt_set);
      pipe_reset_q <= clear_hit;
    end
  end

`ifdef PIPE_RUN_WDOG_EN
  // Fires on the enabled cycle whose increment brings the count to the limit
  assign wdog_hit = (o_cycle_count >= (WDOG_LIMIT - CNT_BITS'(1)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= clear_hit ? 1'b0 : (timeout_q || timeout_set);
    end
  end
`else
  logic unused_wdog;

  assign wdog_hit    = 1'b0;
  assign timeout_q   = 1'b0;
  assign unused_wdog = ^{WDOG_LIMIT, timeout_set};
`endif

  sat_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (o_enable),
    .clr     (clear_hit),
    .count   (o_cycle_count)
  );

  assign o_pipe_reset = pipe_reset_q;
  assign o_halted     = halted_q;
  assign o_timeout    = timeout_q;
  assign o_state      = 3'(state);

endmodule
